alu_exec: RTL



---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_exec_mul_iter.sv | 73 +++++++
 rtl/alu_exec.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the execute stage: default datapath width, opcode
// encodings and the controller state encoding.
package alu_pkg;

  localparam int unsigned WIDTH = 16;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_MOV = 3'b111;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/alu_exec_mul_iter.sv
// Iterative 16-step shift-add multiplier (low WIDTH bits of the product).
// Ports:
//   clk, rst   rising-edge clock, synchronous active-high reset (aborts a run)
//   start      latch a/b, clear accumulator and step counter, begin stepping
//   a, b       operands
//   done       high during the last step; prod is valid in that same cycle
//   prod       accumulator value including the current step
module mul_iter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = alu_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] prod
);

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             run_q, run_d;

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    run_d = run_q;
    if (start) begin
      a_d   = a;
      b_d   = b;
      acc_d = '0;
      cnt_d = '0;
      run_d = 1'b1;
    end else if (run_q) begin
      if (b_q[0]) begin
        acc_d = acc_q + a_q;
      end
      a_d   = a_q << 1;
      b_d   = b_q >> 1;
      cnt_d = cnt_q + 4'd1;
      if (cnt_q == 4'd15) begin
        run_d = 1'b0;
      end
    end
  end

  // The consumer registers prod on the done edge, so expose the post-step sum.
  assign done = run_q && (cnt_q == 4'd15) && !start;
  assign prod = acc_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

endmodule

// File: rtl/alu_exec.sv
// Execute stage: single-cycle ADD/SUB/AND/OR/XOR/SHL/MOV plus a 16-cycle
// iterative MUL. Results are registered and strobed for write-back.
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   en_in         operand-valid strobe (ignored while busy)
//   op, rd_sel    opcode and destination register index
//   alu_a, alu_b  operands
//   busy          multiply in progress
//   en_out        one-cycle result-valid strobe
//   alu_out       result, held between strobes
//   reg_en        one-hot write enable, only during en_out
//   zf, cf        zero / carry flags, updated only on en_out cycles
module alu_exec
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = alu_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_in,
  input  logic [2:0]       op,
  input  logic [1:0]       rd_sel,
  input  logic [WIDTH-1:0] alu_a,
  input  logic [WIDTH-1:0] alu_b,
  output logic             busy,
  output logic             en_out,
  output logic [WIDTH-1:0] alu_out,
  output logic [3:0]       reg_en,
  output logic             zf,
  output logic             cf
);

  state_e           state_q, state_d;
  logic [1:0]       rd_q, rd_d;
  logic             en_out_q, en_out_d;
  logic [WIDTH-1:0] alu_out_q, alu_out_d;
  logic [3:0]       reg_en_q, reg_en_d;
  logic             zf_q, zf_d;
  logic             cf_q, cf_d;

  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_prod;

  logic [WIDTH-1:0]   sc_res;
  logic               sc_cf;
  logic [WIDTH:0]     add_w;
  logic [WIDTH:0]     sub_w;
  logic [2*WIDTH-1:0] shl_w;

  mul_iter #(
    .WIDTH(WIDTH)
  ) u_mul_iter (
    .clk  (clk),
    .rst  (rst),
    .start(mul_start),
    .a    (alu_a),
    .b    (alu_b),
    .done (mul_done),
    .prod (mul_prod)
  );

  // Single-cycle datapath. Widened forms expose carry, borrow and the last
  // bit shifted out at bit WIDTH.
  always_comb begin
    add_w  = {1'b0, alu_a} + {1'b0, alu_b};
    sub_w  = {1'b0, alu_a} - {1'b0, alu_b};
    shl_w  = {{WIDTH{1'b0}}, alu_a} << alu_b[3:0];
    sc_res = '0;
    sc_cf  = 1'b0;
    case (op)
      OP_ADD: begin
        sc_res = add_w[WIDTH-1:0];
        sc_cf  = add_w[WIDTH];
      end
      OP_SUB: begin
        sc_res = sub_w[WIDTH-1:0];
        sc_cf  = sub_w[WIDTH];
      end
      OP_AND: sc_res = alu_a & alu_b;
      OP_OR:  sc_res = alu_a | alu_b;
      OP_XOR: sc_res = alu_a ^ alu_b;
      OP_SHL: begin
        sc_res = shl_w[WIDTH-1:0];
        sc_cf  = shl_w[WIDTH];
      end
      OP_MOV:  sc_res = alu_b;
      default: sc_res = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    rd_d      = rd_q;
    en_out_d  = 1'b0;
    reg_en_d  = 4'b0000;
    alu_out_d = alu_out_q;
    zf_d      = zf_q;
    cf_d      = cf_q;
    mul_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en_in) begin
          if (op == OP_MUL) begin
            mul_start = 1'b1;
            rd_d      = rd_sel;
            state_d   = ST_MUL;
          end else begin
            en_out_d  = 1'b1;
            reg_en_d  = 4'b0001 << rd_sel;
            alu_out_d = sc_res;
            zf_d      = (sc_res == '0);
            cf_d      = sc_cf;
          end
        end
      end
      ST_MUL: begin
        // en_in is deliberately not looked at here: no queuing while busy.
        if (mul_done) begin
          en_out_d  = 1'b1;
          reg_en_d  = 4'b0001 << rd_q;
          alu_out_d = mul_prod;
          zf_d      = (mul_prod == '0);
          cf_d      = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rd_q      <= '0;
      en_out_q  <= 1'b0;
      alu_out_q <= '0;
      reg_en_q  <= 4'b0000;
      zf_q      <= 1'b0;
      cf_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_q      <= rd_d;
      en_out_q  <= en_out_d;
      alu_out_q <= alu_out_d;
      reg_en_q  <= reg_en_d;
      zf_q      <= zf_d;
      cf_q      <= cf_d;
    end
  end

  assign busy    = (state_q == ST_MUL);
  assign en_out  = en_out_q;
  assign alu_out = alu_out_q;
  assign reg_en  = reg_en_q;
  assign zf      = zf_q;
  assign cf      = cf_q;

endmodule
